// File: rtl/pfpu_wbq.sv
// ---------------------------------------------------------------------------
// pfpu_wbq -- PFPU writeback queue
//
// Collects results from two ALU result ports (A and B), buffers them in a
// small in-order FIFO and drives the single register-file write port with one
// result per cycle. When the queue is empty, a newly arriving result bypasses
// the FIFO and appears on the write port the next cycle.
//
// Handshake: valid_a / valid_b are one-cycle strobes with no ready. A result
// is either taken (bypassed or queued) on the edge that samples its strobe,
// or it is dropped, and the drop is recorded in the sticky overflow flag.
// stall_o tells the sequencer to stop issuing early enough that results
// still in the ALU pipelines can be absorbed.
//
// Ports
//   sys_clk, sys_rst_n      clock, asynchronous active-low reset
//   alu_rst                 synchronous flush (queue and write strobe)
//   valid_a/dest_a/r_a      ALU port A result
//   valid_b/dest_b/r_b      ALU port B result
//   ovf_clr                 clears the sticky overflow flag
//   regf_we/waddr/wdat      registered register-file write port
//   stall_o                 queue near full
//   busy_o                  queue non-empty or a write is in flight
//   overflow                sticky: a result was dropped
// ---------------------------------------------------------------------------
module pfpu_wbq #(
  parameter int DEPTH        = 8,
  parameter int STALL_MARGIN = 3
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        alu_rst,
  input  logic        valid_a,
  input  logic [6:0]  dest_a,
  input  logic [31:0] r_a,
  input  logic        valid_b,
  input  logic [6:0]  dest_b,
  input  logic [31:0] r_b,
  input  logic        ovf_clr,
  output logic        regf_we,
  output logic [6:0]  regf_waddr,
  output logic [31:0] regf_wdat,
  output logic        stall_o,
  output logic        busy_o,
  output logic        overflow
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] STALL_TH = CW'(DEPTH - STALL_MARGIN);

  // Each entry is {dest, data}.
  logic [38:0]   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, wr_ptr_b, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d, free, need_b;
  logic          regf_we_q;
  logic [6:0]    regf_waddr_q;
  logic [31:0]   regf_wdat_q;
  logic          overflow_q;

  logic          pop, push_a_req, push_b_req, push_a, push_b, drop;
  logic          sel_we;
  logic [38:0]   sel_ent;

  always_comb begin
    pop        = (count_q != '0);
    // A bypasses only when the queue is empty; B bypasses only when the queue
    // is empty and A is idle. Anything not bypassed wants a FIFO slot.
    push_a_req = valid_a & pop;
    push_b_req = valid_b & (pop | valid_a);
    // The head leaves this edge, so its slot is reusable by the pushes.
    free       = DEPTH_C - count_q + CW'(pop);
    push_a     = push_a_req & (free != '0);
    need_b     = push_a ? CW'(2) : CW'(1);
    push_b     = push_b_req & (free >= need_b);
    drop       = (push_a_req & ~push_a) | (push_b_req & ~push_b);

    wr_ptr_b   = wr_ptr_q + PW'(push_a);
    wr_ptr_d   = wr_ptr_q + PW'(push_a) + PW'(push_b);
    rd_ptr_d   = rd_ptr_q + PW'(pop);
    count_d    = count_q + CW'(push_a) + CW'(push_b) - CW'(pop);

    sel_we  = 1'b1;
    sel_ent = mem_q[rd_ptr_q];
    if (!pop) begin
      if (valid_a)      sel_ent = {dest_a, r_a};
      else if (valid_b) sel_ent = {dest_b, r_b};
      else              sel_we  = 1'b0;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      regf_we_q    <= 1'b0;
      regf_waddr_q <= '0;
      regf_wdat_q  <= '0;
      overflow_q   <= 1'b0;
    end else if (alu_rst) begin
      // Flush: inputs this cycle are discarded, overflow is left alone.
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      regf_we_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      regf_we_q <= sel_we;
      if (sel_we) begin
        regf_waddr_q <= sel_ent[38:32];
        regf_wdat_q  <= sel_ent[31:0];
      end
      // A new drop wins over a simultaneous clear.
      if (drop)         overflow_q <= 1'b1;
      else if (ovf_clr) overflow_q <= 1'b0;
    end
  end

  // Storage array is not reset; only slots between the pointers are valid.
  always_ff @(posedge sys_clk) begin
    if (!alu_rst) begin
      if (push_a) mem_q[wr_ptr_q] <= {dest_a, r_a};
      if (push_b) mem_q[wr_ptr_b] <= {dest_b, r_b};
    end
  end

  assign regf_we    = regf_we_q;
  assign regf_waddr = regf_waddr_q;
  assign regf_wdat  = regf_wdat_q;
  assign overflow   = overflow_q;
  assign stall_o    = (count_q >= STALL_TH);
  assign busy_o     = (count_q != '0) | regf_we_q;

endmodule

// File: tb/tb_pfpu_wbq.sv
module tb_pfpu_wbq;

  // ---------------- clock / reset ----------------
  logic        sys_clk   = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        alu_rst   = 1'b0;
  logic        valid_a   = 1'b0;
  logic [6:0]  dest_a    = '0;
  logic [31:0] r_a       = '0;
  logic        valid_b   = 1'b0;
  logic [6:0]  dest_b    = '0;
  logic [31:0] r_b       = '0;
  logic        ovf_clr   = 1'b0;
  logic        regf_we;
  logic [6:0]  regf_waddr;
  logic [31:0] regf_wdat;
  logic        stall_o;
  logic        busy_o;
  logic        overflow;

  always #5 sys_clk = ~sys_clk;

  pfpu_wbq #(.DEPTH(8), .STALL_MARGIN(3)) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .alu_rst    (alu_rst),
    .valid_a    (valid_a),
    .dest_a     (dest_a),
    .r_a        (r_a),
    .valid_b    (valid_b),
    .dest_b     (dest_b),
    .r_b        (r_b),
    .ovf_clr    (ovf_clr),
    .regf_we    (regf_we),
    .regf_waddr (regf_waddr),
    .regf_wdat  (regf_wdat),
    .stall_o    (stall_o),
    .busy_o     (busy_o),
    .overflow   (overflow)
  );

  // ---------------- scoreboard ----------------
  logic [38:0] exp_q[$];
  logic [38:0] mon_ent;
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic expect_wr(input logic [6:0] d, input logic [31:0] x);
    exp_q.push_back({d, x});
  endtask

  // Monitor: every register-file write must match the head of the queue.
  always @(negedge sys_clk) begin
    if (sys_rst_n && regf_we) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_write: got %h/%h expected none", regf_waddr, regf_wdat);
      end else begin
        mon_ent = exp_q.pop_front();
        if ({regf_waddr, regf_wdat} !== mon_ent) begin
          n_err++;
          $display("FAIL write_order: got %h/%h expected %h/%h",
                   regf_waddr, regf_wdat, mon_ent[38:32], mon_ent[31:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic va, input logic [6:0] da, input logic [31:0] ra,
                      input logic vb, input logic [6:0] db, input logic [31:0] rb,
                      input logic clr, input logic flush);
    valid_a = va; dest_a = da; r_a = ra;
    valid_b = vb; dest_b = db; r_b = rb;
    ovf_clr = clr; alu_rst = flush;
    @(posedge sys_clk);
    #1;
    valid_a = 1'b0; valid_b = 1'b0; ovf_clr = 1'b0; alu_rst = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, 7'd0, 32'd0, 1'b0, 7'd0, 32'd0, 1'b0, 1'b0);
  endtask

  // Dual push with id i; A goes to dest i, B to dest i+64.
  task automatic dual(input int i, input logic exp_a, input logic exp_b,
                      input logic clr, input logic flush);
    if (exp_a) expect_wr(7'(i), 32'hA000_0000 + 32'(i));
    if (exp_b) expect_wr(7'(i + 64), 32'hB000_0000 + 32'(i));
    step(1'b1, 7'(i), 32'hA000_0000 + 32'(i),
         1'b1, 7'(i + 64), 32'hB000_0000 + 32'(i), clr, flush);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy_o && n < 40) begin
      @(posedge sys_clk);
      #1;
      n++;
    end
    check(name, 32'(busy_o), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset state
    #3;
    check("rst_we", 32'(regf_we), 32'd0);
    check("rst_waddr", 32'(regf_waddr), 32'd0);
    check("rst_wdat", regf_wdat, 32'd0);
    check("rst_stall", 32'(stall_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    #9 sys_rst_n = 1'b1;
    @(posedge sys_clk);
    #1;

    // 1: single A into empty queue, 1-cycle latency
    expect_wr(7'd5, 32'h3F80_0000);
    step(1'b1, 7'd5, 32'h3F80_0000, 1'b0, 7'd0, 32'd0, 1'b0, 1'b0);
    check("t1_we", 32'(regf_we), 32'd1);
    idle();
    check("t1_we_off", 32'(regf_we), 32'd0);
    check("t1_busy_off", 32'(busy_o), 32'd0);

    // 2: A and B in the same cycle, written on consecutive cycles
    expect_wr(7'd1, 32'h11);
    expect_wr(7'd2, 32'h22);
    step(1'b1, 7'd1, 32'h11, 1'b1, 7'd2, 32'h22, 1'b0, 1'b0);
    check("t2_busy", 32'(busy_o), 32'd1);
    idle();
    check("t2_we_second", 32'(regf_we), 32'd1);
    check("t2_stall", 32'(stall_o), 32'd0);
    idle();
    check("t2_busy_off", 32'(busy_o), 32'd0);

    // 3/4: dual pushes every cycle; count grows by one per cycle
    for (int i = 1; i <= 8; i++) begin
      dual(i, 1'b1, 1'b1, 1'b0, 1'b0);
      check($sformatf("t3_stall_%0d", i), 32'(stall_o), (i >= 5) ? 32'd1 : 32'd0);
    end
    check("t3_no_ovf", 32'(overflow), 32'd0);
    dual(9, 1'b1, 1'b0, 1'b0, 1'b0);   // queue full: B dropped
    check("t4_ovf_set", 32'(overflow), 32'd1);
    dual(10, 1'b1, 1'b0, 1'b1, 1'b0);  // drop together with clear
    check("t4_ovf_clr_vs_drop", 32'(overflow), 32'd1);
    wait_idle("t4_drain");
    step(1'b0, 7'd0, 32'd0, 1'b0, 7'd0, 32'd0, 1'b1, 1'b0);
    check("t4_ovf_cleared", 32'(overflow), 32'd0);

    // 5: flush while draining with count=6
    for (int i = 1; i <= 6; i++)
      dual(i + 20, (i <= 3), (i <= 3), 1'b0, 1'b0);
    check("t5_stall_pre", 32'(stall_o), 32'd1);
    dual(30, 1'b0, 1'b0, 1'b0, 1'b1);
    check("t5_we", 32'(regf_we), 32'd0);
    check("t5_busy", 32'(busy_o), 32'd0);
    check("t5_stall", 32'(stall_o), 32'd0);
    expect_wr(7'd9, 32'h1234_5678);
    step(1'b1, 7'd9, 32'h1234_5678, 1'b0, 7'd0, 32'd0, 1'b0, 1'b0);
    check("t5_after_we", 32'(regf_we), 32'd1);
    idle();
    check("t5_after_busy", 32'(busy_o), 32'd0);

    // 6: asynchronous reset mid-cycle while writing
    for (int i = 1; i <= 9; i++)
      dual(i + 40, 1'b1, (i <= 8), 1'b0, 1'b0);
    check("t6_pre_we", 32'(regf_we), 32'd1);
    check("t6_pre_stall", 32'(stall_o), 32'd1);
    check("t6_pre_ovf", 32'(overflow), 32'd1);
    #2 sys_rst_n = 1'b0;
    #1;
    check("t6_we", 32'(regf_we), 32'd0);
    check("t6_busy", 32'(busy_o), 32'd0);
    check("t6_stall", 32'(stall_o), 32'd0);
    check("t6_ovf", 32'(overflow), 32'd0);
    check("t6_waddr", 32'(regf_waddr), 32'd0);
    check("t6_wdat", regf_wdat, 32'd0);
    exp_q.delete();
    @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;
    expect_wr(7'd3, 32'hCAFE_F00D);
    step(1'b1, 7'd3, 32'hCAFE_F00D, 1'b0, 7'd0, 32'd0, 1'b0, 1'b0);
    check("t6_post_we", 32'(regf_we), 32'd1);
    idle();
    check("t6_post_busy", 32'(busy_o), 32'd0);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
